// File: rtl/mat_rowsum.sv
// rtl/mat_rowsum.sv - row-sum stage: reads each row of C from memory, writes one sum word per row.
// Optional build macro: ROWSUM_SAT_EN (unsigned saturating accumulate instead of wrap).
module mat_rowsum #(
    parameter int MEM_AW   = 16,
    parameter int MEM_DW   = 32,
    parameter int DIM_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                sm_ena,
    input  logic [MEM_AW-1:0]   cBASE,
    input  logic [DIM_BITS-1:0] cSTRIDE,
    input  logic [DIM_BITS-1:0] cROWS,
    input  logic [DIM_BITS-1:0] cCOLS,
    input  logic [MEM_AW-1:0]   sBASE,
    output logic                mem_req,
    output logic                mem_write,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [MEM_DW-1:0]   mem_wdata,
    input  logic                mem_rdata_vld,
    input  logic [MEM_DW-1:0]   mem_rdata,
    output logic                ret
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state_q, state_n;
    logic [DIM_BITS-1:0] i_q, i_n, j_q, j_n;
    logic [MEM_DW-1:0]   acc_q, acc_n;
    logic [MEM_AW-1:0]   row_q, row_n;
    logic [DIM_BITS-1:0] stride_q, stride_n, rows_q, rows_n, cols_q, cols_n;
    logic [MEM_AW-1:0]   sbase_q, sbase_n;
    logic [MEM_DW-1:0]   hold_q;
    logic                pend_q;

    logic [DIM_BITS-1:0] i_inc, j_inc;
    logic                take;
    logic [MEM_DW-1:0]   rd_word, acc_add;
    logic                issue;

    assign i_inc   = i_q + 1'b1;
    assign j_inc   = j_q + 1'b1;
    // Read data is taken either straight off the bus or from the hold register filled while frozen.
    assign take    = mem_rdata_vld | pend_q;
    assign rd_word = mem_rdata_vld ? mem_rdata : hold_q;

`ifdef ROWSUM_SAT_EN
    logic [MEM_DW:0] sum_w;
    assign sum_w   = {1'b0, acc_q} + {1'b0, rd_word};
    assign acc_add = sum_w[MEM_DW] ? {MEM_DW{1'b1}} : sum_w[MEM_DW-1:0];
`else
    assign acc_add = acc_q + rd_word;
`endif

    always_comb begin
        state_n  = state_q;
        i_n      = i_q;
        j_n      = j_q;
        acc_n    = acc_q;
        row_n    = row_q;
        stride_n = stride_q;
        rows_n   = rows_q;
        cols_n   = cols_q;
        sbase_n  = sbase_q;
        if (sm_ena) begin
            case (state_q)
                S_IDLE: if (go) begin
                    i_n      = '0;
                    j_n      = '0;
                    acc_n    = '0;
                    row_n    = cBASE;
                    stride_n = cSTRIDE;
                    rows_n   = cROWS;
                    cols_n   = cCOLS;
                    sbase_n  = sBASE;
                    if (cROWS == '0)      state_n = S_DONE;
                    else if (cCOLS == '0) state_n = S_WR;
                    else                  state_n = S_RD;
                end
                S_RD: state_n = S_WAIT;
                S_WAIT: if (take) begin
                    acc_n   = acc_add;
                    j_n     = j_inc;
                    state_n = (j_inc == cols_q) ? S_WR : S_RD;
                end
                S_WR: begin
                    i_n   = i_inc;
                    j_n   = '0;
                    acc_n = '0;
                    row_n = row_q + MEM_AW'(stride_q);
                    if (i_inc == rows_q)     state_n = S_DONE;
                    else if (cols_q == '0)   state_n = S_WR;
                    else                     state_n = S_RD;
                end
                S_DONE: state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Strobes are launched on entry so the access is on the bus during the RD/WR cycle itself.
    assign issue = sm_ena && (state_n == S_RD || state_n == S_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            row_q     <= '0;
            stride_q  <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            sbase_q   <= '0;
            hold_q    <= '0;
            pend_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ret       <= 1'b0;
        end else begin
            state_q  <= state_n;
            i_q      <= i_n;
            j_q      <= j_n;
            acc_q    <= acc_n;
            row_q    <= row_n;
            stride_q <= stride_n;
            rows_q   <= rows_n;
            cols_q   <= cols_n;
            sbase_q  <= sbase_n;

            if (state_q == S_IDLE) begin
                pend_q <= 1'b0;
            end else if (mem_rdata_vld && !(sm_ena && state_q == S_WAIT)) begin
                hold_q <= mem_rdata;
                pend_q <= 1'b1;
            end else if (sm_ena && state_q == S_WAIT) begin
                pend_q <= 1'b0;
            end

            mem_req <= issue;
            ret     <= sm_ena && (state_n == S_DONE);
            if (issue) begin
                mem_write <= (state_n == S_WR);
                if (state_n == S_WR) begin
                    mem_addr  <= sbase_n + MEM_AW'(i_n);
                    mem_wdata <= acc_n;
                end else begin
                    mem_addr  <= row_n + MEM_AW'(j_n);
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_rowsum.sv
// tb/tb_mat_rowsum.sv - self-checking bench for mat_rowsum with a variable-latency memory model.
module tb_mat_rowsum;

    logic        clk = 1'b0;
    logic        rst, go, sm_ena;
    logic [15:0] cBASE, cSTRIDE, cROWS, cCOLS, sBASE;
    logic        mem_req, mem_write, mem_rdata_vld, ret;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mat_rowsum #(.MEM_AW(16), .MEM_DW(32), .DIM_BITS(16)) dut (
        .clk(clk), .rst(rst), .go(go), .sm_ena(sm_ena),
        .cBASE(cBASE), .cSTRIDE(cSTRIDE), .cROWS(cROWS), .cCOLS(cCOLS), .sBASE(sBASE),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata), .ret(ret)
    );

    logic [31:0] mem [0:65535];
    logic [15:0] wlog_addr [0:1023];
    logic [31:0] wlog_data [0:1023];
    int          lat = 1;
    int          rd_total = 0, wr_total = 0, ret_total = 0;
    int          checks = 0, passes = 0, fails = 0;

    logic        rpend = 1'b0;
    int          rcnt = 0;
    logic [15:0] raddr = '0;

    // Memory: reads answer 'lat' cycles after the strobe; writes go to a log only.
    always @(posedge clk) begin
        mem_rdata_vld <= 1'b0;
        if (mem_req && mem_write) begin
            wlog_addr[wr_total[9:0]] <= mem_addr;
            wlog_data[wr_total[9:0]] <= mem_wdata;
            wr_total <= wr_total + 1;
        end
        if (mem_req && !mem_write) begin
            rd_total <= rd_total + 1;
            if (lat == 1) begin
                mem_rdata_vld <= 1'b1;
                mem_rdata     <= mem[mem_addr];
            end else begin
                rpend <= 1'b1;
                rcnt  <= lat - 2;
                raddr <= mem_addr;
            end
        end else if (rpend) begin
            if (rcnt == 0) begin
                mem_rdata_vld <= 1'b1;
                mem_rdata     <= mem[raddr];
                rpend         <= 1'b0;
            end else begin
                rcnt <= rcnt - 1;
            end
        end
        if (ret) ret_total <= ret_total + 1;
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    function automatic logic [31:0] row_sum(input logic [15:0] cb, input logic [15:0] st,
                                            input int i, input logic [15:0] cols);
        logic [32:0] s;
        s = '0;
        for (int j = 0; j < cols; j++) begin
            s = {1'b0, s[31:0]} + {1'b0, mem[16'(cb + i * st + j)]};
`ifdef ROWSUM_SAT_EN
            if (s[32]) s = 33'h0_FFFF_FFFF;
`endif
        end
        return s[31:0];
    endfunction

    task automatic run(input string tag, input logic [15:0] cb, input logic [15:0] st,
                       input logic [15:0] rows, input logic [15:0] cols, input logic [15:0] sb,
                       input int frz, input bit chk_cyc, output int wbase);
        logic [31:0] expv [$];
        int r0, t0, cyc, bad;
        bit done, frozen;
        for (int i = 0; i < rows; i++) expv.push_back(row_sum(cb, st, i, cols));
        @(negedge clk);
        cBASE = cb; cSTRIDE = st; cROWS = rows; cCOLS = cols; sBASE = sb; go = 1'b1;
        r0 = rd_total; wbase = wr_total; t0 = ret_total;
        cyc = 0; bad = 0; done = 0; frozen = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            go = 1'b0;
            cyc++;
            if (frz != 0 && !frozen && rd_total - r0 == frz) begin
                sm_ena = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (mem_req || ret) bad++;
                end
                sm_ena = 1'b1;
                frozen = 1;
            end else if (ret) begin
                done = 1;
            end
        end
        chk({tag, " ret_seen"}, 64'(done), 64'd1);
        @(negedge clk);
        chk({tag, " ret_once"}, 64'(ret_total - t0), 64'd1);
        chk({tag, " reads"}, 64'(rd_total - r0), 64'(int'(rows) * int'(cols)));
        chk({tag, " writes"}, 64'(wr_total - wbase), 64'(rows));
        for (int i = 0; i < rows && i < wr_total - wbase; i++) begin
            chk($sformatf("%s waddr%0d", tag, i), 64'(wlog_addr[10'(wbase + i)]), 64'(16'(sb + i)));
            chk($sformatf("%s sum%0d", tag, i), 64'(wlog_data[10'(wbase + i)]), 64'(expv[i]));
        end
        if (chk_cyc)
            chk({tag, " cycles"}, 64'(cyc), 64'(int'(rows) * (int'(cols) * (lat + 1) + 1) + 1));
        if (frz != 0) begin
            chk({tag, " frozen_entered"}, 64'(frozen), 64'd1);
            chk({tag, " no_req_frozen"}, 64'(bad), 64'd0);
        end
    endtask

    int wb, cnt, r0, w0;
    logic [31:0] a [6][4];
    logic [31:0] b [4][5];
    logic [31:0] golden;
    logic [15:0] rr, cc;

    initial begin
        rst = 1'b1; go = 1'b0; sm_ena = 1'b1;
        cBASE = '0; cSTRIDE = '0; cROWS = '0; cCOLS = '0; sBASE = '0;
        for (int k = 0; k < 65536; k++) mem[k] = 32'(k);
        repeat (2) @(negedge clk);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_write", 64'(mem_write), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst ret", 64'(ret), 64'd0);
        rst = 1'b0;

        lat = $urandom_range(1, 4);
        run("basic", 16'h0300, 16'd8, 16'd6, 16'd5, 16'h0400, 0, 1, wb);

        // C = A*B laid out at 0x300 with pitch 8; golden row sum via sum_k a[i][k]*rowsum(b[k]).
        for (int i = 0; i < 6; i++) for (int k = 0; k < 4; k++) a[i][k] = $urandom_range(0, 1000);
        for (int k = 0; k < 4; k++) for (int j = 0; j < 5; j++) b[k][j] = $urandom_range(0, 1000);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5; j++) begin
                mem[16'h0300 + 8 * i + j] = 0;
                for (int k = 0; k < 4; k++) mem[16'h0300 + 8 * i + j] += a[i][k] * b[k][j];
            end
        lat = $urandom_range(1, 4);
        run("chain", 16'h0300, 16'd8, 16'd6, 16'd5, 16'h0400, 0, 1, wb);
        for (int i = 0; i < 6; i++) begin
            golden = 0;
            for (int k = 0; k < 4; k++) golden += a[i][k] * (b[k][0] + b[k][1] + b[k][2] + b[k][3] + b[k][4]);
            chk($sformatf("chain golden%0d", i), 64'(wlog_data[10'(wb + i)]), 64'(golden));
        end

        run("rows0", 16'h0300, 16'd8, 16'd0, 16'd5, 16'h0400, 0, 1, wb);
        run("cols0", 16'h0300, 16'd8, 16'd3, 16'd0, 16'h0480, 0, 1, wb);

        for (int k = 16'h2000; k < 16'h2100; k++) mem[k] = $urandom;
        lat = 3;
        run("freeze", 16'h2000, 16'd10, 16'd4, 16'd6, 16'h2400, 3, 0, wb);
        run("nofreeze", 16'h2000, 16'd10, 16'd4, 16'd6, 16'h2400, 0, 1, wb);

        for (int k = 16'h0500; k < 16'h0510; k++) mem[k] = 32'hFFFF_FFFF;
        lat = $urandom_range(1, 4);
        run("ovf", 16'h0500, 16'd4, 16'd2, 16'd2, 16'h0600, 0, 1, wb);
`ifdef ROWSUM_SAT_EN
        chk("ovf const", 64'(wlog_data[10'(wb)]), 64'h0000_0000_FFFF_FFFF);
`else
        chk("ovf const", 64'(wlog_data[10'(wb)]), 64'h0000_0000_FFFF_FFFE);
`endif

        for (int t = 0; t < 3; t++) begin
            for (int k = 16'h3000; k < 16'h3100; k++) mem[k] = $urandom;
            lat = $urandom_range(1, 4);
            rr = 16'($urandom_range(1, 4));
            cc = 16'($urandom_range(1, 5));
            run($sformatf("rand%0d", t), 16'h3000, cc + 16'($urandom_range(0, 3)), rr, cc, 16'h3800, 0, 1, wb);
        end

        // Abort in WAIT of row 2, then a clean rerun.
        lat = 2;
        @(negedge clk);
        cBASE = 16'h0300; cSTRIDE = 16'd8; cROWS = 16'd4; cCOLS = 16'd3; sBASE = 16'h0700; go = 1'b1;
        r0 = rd_total; w0 = wr_total; cnt = 0;
        @(negedge clk);
        go = 1'b0;
        while (!(wr_total - w0 == 2 && rd_total - r0 == 7) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort reached", 64'(cnt < 2000), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort mem_req", 64'(mem_req), 64'd0);
        chk("abort mem_write", 64'(mem_write), 64'd0);
        chk("abort mem_addr", 64'(mem_addr), 64'd0);
        chk("abort mem_wdata", 64'(mem_wdata), 64'd0);
        chk("abort ret", 64'(ret), 64'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req || ret) cnt++;
        end
        chk("abort idle", 64'(cnt), 64'd0);
        run("rerun", 16'h0300, 16'd8, 16'd4, 16'd3, 16'h0700, 0, 1, wb);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mat_rowsum.md
Name: mat_rowsum

Overview:
- Memory-mastering stage directly downstream of matmul.
- After matmul returns, reads each row of result matrix C from shared memory, accumulates the row sum, and writes one sum word per row to a destination vector.
- Uses the same single-port mem request interface and go/ret/sm_ena control style as matmul, so a tb can chain matmul -> mat_rowsum on one mem instance.

Parameters:
- MEM_AW, 16, memory address width.
- MEM_DW, 32, memory data width; accumulator width.
- DIM_BITS, 16, width of ROWS/COLS/STRIDE.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- go  input  1  start request, sampled in IDLE only.
- sm_ena  input  1  FSM advance enable; low freezes FSM.
- cBASE  input  MEM_AW  base address of source matrix.
- cSTRIDE  input  DIM_BITS  source row pitch in words.
- cROWS  input  DIM_BITS  source rows.
- cCOLS  input  DIM_BITS  source columns.
- sBASE  input  MEM_AW  destination vector base address.
- mem_req  output  1  one-cycle access strobe.
- mem_write  output  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  output  MEM_AW  access address; valid with mem_req.
- mem_wdata  output  MEM_DW  write data; valid with mem_req & mem_write.
- mem_rdata_vld  input  1  read data valid, one pulse per read, latency >= 1 cycle.
- mem_rdata  input  MEM_DW  read data.
- ret  output  1  one-cycle done pulse.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, ret=0; i, j, acc, row address cleared.
- Reset mid-operation aborts immediately. Any later mem_rdata_vld is ignored because state is IDLE.
- Inputs cBASE..sBASE are latched on go acceptance; later changes have no effect until the next go.
- All outputs are registered.
- States:
  - IDLE: if go & sm_ena, latch inputs, i=0, j=0, acc=0, rowaddr=cBASE. If cROWS==0 -> DONE, elif cCOLS==0 -> WR, else -> RD.
  - RD: mem_req=1, mem_write=0, mem_addr=rowaddr+j (mod 2^MEM_AW), for exactly one cycle -> WAIT.
  - WAIT: on captured rdata valid, acc=acc+rdata (mod 2^MEM_DW), j=j+1. If j+1==cCOLS -> WR, else -> RD.
  - WR: mem_req=1, mem_write=1, mem_addr=sBASE+i, mem_wdata=acc, one cycle. Then i=i+1, j=0, acc=0, rowaddr=rowaddr+cSTRIDE. If i+1==cROWS -> DONE, else (cCOLS==0 ? WR : RD).
  - DONE: ret=1 for one cycle -> IDLE.
- Outstanding reads: at most one read is outstanding at any time. The next read is not issued before the previous read's data returns.
- First mem_req is asserted in the cycle after go is accepted.
- sm_ena=0:
  - No state transition occurs; i, j, acc and rowaddr hold.
  - mem_req and ret are forced 0; a pending RD or WR issues once sm_ena returns high.
  - mem_rdata_vld arriving while sm_ena=0 is captured into a hold register plus pending flag and consumed in WAIT when enabled. No data is lost.
- go while not IDLE is ignored.
- go held high through DONE starts a new run from IDLE on the next cycle.
- Throughput with fixed read latency L: row cost = cCOLS*(L+1)+1 cycles. Total = 1 + cROWS*(cCOLS*(L+1)+1) + 1 cycles.

Optional Feature:
- ROWSUM_SAT_EN defined: the accumulate clamps at 2^MEM_DW-1 (unsigned saturate). Once saturated, acc stays at max for the rest of the row.
- ROWSUM_SAT_EN undefined: the accumulate wraps modulo 2^MEM_DW.

Test Plan:
- Basic: mem init_incr, cBASE=0x300, cROWS=6, cCOLS=5, cSTRIDE=8, sBASE=0x400, go pulse -> mem[0x400+i] = sum over j of mem[0x300+8i+j] for i=0..5. Exactly 36 mem_req pulses (30 reads, 6 writes). ret pulses once.
- Chained with matmul: matmul on (aROWS=6, aCOLS=4, bCOLS=5, strides 4/5/8), then mat_rowsum on C -> each of 6 sums matches the bench golden row sum of A*B. Zero errors.
- Zero dims: cROWS=0 -> ret 2 cycles after go, no mem_req. cROWS=3, cCOLS=0 -> 3 writes of 0 to sBASE..sBASE+2.
- sm_ena freeze: drop sm_ena for 20 cycles in WAIT with rdata_vld arriving during the freeze -> no mem_req while low, final sums identical to the unfrozen run.
- Overflow: rows of 0xFFFFFFFF, cCOLS=2 -> sum 0xFFFFFFFE without ROWSUM_SAT_EN, 0xFFFFFFFF with it.
- Reset mid-run: rst=1 for 1 cycle in WAIT of row 2 -> outputs return to reset values next cycle. A new go completes a full, correct run.
